otter_mem_arbiter: RTL

- Shares the single data/instruction port of a unified OTTER memory between two requesters: instruction fetch (IF stage) and data access (MEM stage loads/stores).
- Issues at most one memory command per cycle and tracks in-flight reads through a tag pipeline.
- Routes each read response back to the requester that issued it.
- Supports IF flush on branch_taken and an anti-starvation scheduler for fetch.

---
 rtl/otter_arb_pkg.sv | 46 ++++
 rtl/arb_tag_pipe.sv | 45 ++++
 rtl/otter_mem_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/otter_arb_pkg.sv
// Shared types and constants for the OTTER unified-memory arbiter.
// Requester ids, arbiter FSM states, the in-flight tag record and the
// memory access size encodings all live here.
package otter_arb_pkg;

  // Which requester issued a memory command.
  typedef enum logic {
    ARB_IF = 1'b0,
    ARB_DM = 1'b1
  } arb_id_t;

  // Arbiter scheduling state (only used when fairness is built in).
  typedef enum logic {
    ARB_NORMAL     = 1'b0,
    ARB_FETCH_PRIO = 1'b1
  } arb_state_t;

  // One slot of the read-tag pipeline.
  typedef struct packed {
    logic    valid;
    arb_id_t id;
  } arb_tag_t;

  // Access size encodings on dm_size / mem_size.
  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  localparam arb_tag_t TAG_NONE = '{valid: 1'b0, id: ARB_IF};

  // True for the three size codes the memory understands.
  function automatic logic size_is_legal(input logic [1:0] size);
    return (size == MEM_BYTE) || (size == MEM_HALF) || (size == MEM_WORD);
  endfunction

  // Drop a tag if it belongs to fetch and a fetch flush is active.
  function automatic arb_tag_t kill_fetch(input arb_tag_t t, input logic flush);
    arb_tag_t r;
    r = t;
    if (flush && (t.id == ARB_IF)) begin
      r.valid = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// MEM_LAT-deep shift register of read tags {valid, id}.
// Stage 0 is loaded on every cycle (valid only for read grants); the last
// stage identifies the owner of the data on mem_rdata this cycle.
// A fetch flush clears every fetch tag, including the one leaving the
// final stage in the same cycle, so no stale instruction is delivered.
module arb_tag_pipe
  import otter_arb_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic load_valid,
  input  logic load_id,
  input  logic flush_if,
  output logic tail_valid,
  output logic tail_id
);

  arb_tag_t stage [MEM_LAT];
  arb_tag_t load_tag;
  arb_tag_t tail_tag;

  assign load_tag = '{valid: load_valid, id: arb_id_t'(load_id)};

  // Shift tags one stage per cycle, removing fetch tags on a flush.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        stage[i] <= TAG_NONE;
      end
    end else begin
      stage[0] <= kill_fetch(load_tag, flush_if);
      for (int i = 1; i < MEM_LAT; i++) begin
        stage[i] <= kill_fetch(stage[i-1], flush_if);
      end
    end
  end

  assign tail_tag   = kill_fetch(stage[MEM_LAT-1], flush_if);
  // Responses are suppressed while reset is held.
  assign tail_valid = RESET_N & tail_tag.valid;
  assign tail_id    = tail_tag.id;

endmodule

// File: rtl/otter_mem_arbiter.sv
// OTTER unified-memory arbiter: shares one memory port between instruction
// fetch and data access, one command per cycle, and routes read responses
// back to their issuer through a tag pipeline.
//
// Handshake: a requester holds *_req (and its address/data) until it sees
// *_gnt high in the same cycle; the command is issued on mem_* in that
// cycle. Read data returns MEM_LAT cycles later with the matching *_rvalid
// high for exactly one cycle. There is no back-pressure on responses.
//
// Build option OTTER_ARB_FAIRNESS_EN: when defined, a starvation counter
// and a FETCH_PRIO state give fetch priority after STARVE_MAX denied
// cycles. When undefined, data always wins and STARVE_MAX is ignored.
// dbg_state / dbg_starve_cnt expose the scheduler (constant 0 without it).
module otter_mem_arbiter
  import otter_arb_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4,
  localparam int CNT_W     = $clog2(STARVE_MAX + 1)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  // fetch requester
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  input  logic             if_flush,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [31:0]      if_rdata,
  // data requester
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [31:0]      dm_addr,
  input  logic [31:0]      dm_wdata,
  input  logic [1:0]       dm_size,
  input  logic             dm_sign,
  output logic             dm_gnt,
  output logic             dm_rvalid,
  output logic [31:0]      dm_rdata,
  // memory port
  output logic             mem_en,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [1:0]       mem_size,
  output logic             mem_sign,
  input  logic [31:0]      mem_rdata,
  // scheduler observation
  output logic             dbg_state,
  output logic [CNT_W-1:0] dbg_starve_cnt
);

  localparam logic ST_NORMAL     = 1'(ARB_NORMAL);
  localparam logic ST_FETCH_PRIO = 1'(ARB_FETCH_PRIO);

  logic             state;
  logic [CNT_W-1:0] starve_cnt;
  logic             fetch_prio;
  logic             if_ok;
  logic             rd_grant;
  logic             tail_valid;
  logic             tail_id;

  // A fetch can only be considered when not flushed and out of reset.
  assign if_ok = RESET_N & if_req & ~if_flush;

`ifdef OTTER_ARB_FAIRNESS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  // Count denied fetch cycles and switch to fetch priority when starved.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= ST_NORMAL;
      starve_cnt <= '0;
    end else begin
      if (if_gnt) begin
        starve_cnt <= '0;
      end else if (if_req && !if_flush && (starve_cnt != CNT_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
      case (state)
        ST_NORMAL: begin
          if (starve_cnt == CNT_MAX) begin
            state <= ST_FETCH_PRIO;
          end
        end
        default: begin
          if (if_gnt) begin
            state <= ST_NORMAL;
          end
        end
      endcase
    end
  end

  assign fetch_prio = (state == ST_FETCH_PRIO);
`else
  assign state      = ST_NORMAL;
  assign starve_cnt = '0;
  assign fetch_prio = 1'b0;
`endif

  assign dbg_state      = state;
  assign dbg_starve_cnt = starve_cnt;

  // Same-cycle grants; data wins unless fetch has been starved.
  assign if_gnt = fetch_prio ? if_ok : (if_ok & ~dm_req);
  assign dm_gnt = RESET_N & dm_req & ~(fetch_prio & if_ok);
  assign mem_en = if_gnt | dm_gnt;

  // Drive the memory command from whichever requester holds the grant.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_size  = '0;
    mem_sign  = 1'b0;
    if (if_gnt) begin
      mem_addr = if_addr;
      mem_size = MEM_WORD;
    end else if (dm_gnt) begin
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      mem_size  = dm_size;
      mem_sign  = dm_sign;
    end
  end

  // Only reads produce a response; stores enter the pipe as bubbles.
  assign rd_grant = if_gnt | (dm_gnt & ~dm_we);

  arb_tag_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_tag_pipe (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .load_valid (rd_grant),
    .load_id    (if_gnt ? 1'(ARB_IF) : 1'(ARB_DM)),
    .flush_if   (if_flush),
    .tail_valid (tail_valid),
    .tail_id    (tail_id)
  );

  // Steer the response to its owner; data is shared and qualified by rvalid.
  assign if_rvalid = tail_valid & (tail_id == 1'(ARB_IF));
  assign dm_rvalid = tail_valid & (tail_id == 1'(ARB_DM));
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;

endmodule
